// File: rtl/uart_status_tx.sv
// UART transmitter with byte FIFO and a 4-byte status-frame sequencer (A5, level, mode, checksum).
// Define UART_STATUS_TX_PARITY_EN for 8E1 framing; the default build sends 8N1.
module uart_status_tx #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       status_req,
    input  logic [1:0] bright_level,
    input  logic [1:0] roll_ctrl,
    output logic       tx,
    output logic       busy,
    output logic       req_drop
);

    localparam int unsigned BAUD_DIV  = CLK_FREQ / BAUD;
    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam int unsigned CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [7:0]    SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_STATUS_TX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd3
    } tx_state_e;

    // FIFO storage and pointers
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        empty, full;
    logic        push, pop;
    logic [7:0]  push_data;

    // Status sequencer
    logic       seq_active_q, seq_active_d;
    logic [1:0] seq_idx_q, seq_idx_d;
    logic [7:0] b1_q, b1_d;
    logic [7:0] b2_q, b2_d;
    logic [7:0] ck_q, ck_d;
    logic       req_drop_q, req_drop_d;
    logic [7:0] seq_byte;

    // Serializer
    tx_state_e   state_q;
    logic [CW-1:0] baud_cnt_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shreg_q;
    logic        tx_q;
`ifdef UART_STATUS_TX_PARITY_EN
    logic        parity_q;
`endif

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = (state_q == S_IDLE) && !empty;

    always_comb begin
        unique case (seq_idx_q)
            2'd0:    seq_byte = SYNC_BYTE;
            2'd1:    seq_byte = b1_q;
            2'd2:    seq_byte = b2_q;
            default: seq_byte = ck_q;
        endcase
    end

    // The sequencer owns the FIFO write port while active; user bytes only get it when idle.
    always_comb begin
        seq_active_d = seq_active_q;
        seq_idx_d    = seq_idx_q;
        b1_d         = b1_q;
        b2_d         = b2_q;
        ck_d         = ck_q;
        req_drop_d   = status_req && seq_active_q;
        push         = 1'b0;
        push_data    = tx_data;
        if (seq_active_q) begin
            if (!full) begin
                push      = 1'b1;
                push_data = seq_byte;
                seq_idx_d = seq_idx_q + 2'd1;
                if (seq_idx_q == 2'd3) begin
                    seq_active_d = 1'b0;
                end
            end
        end else begin
            if (tx_valid && !full) begin
                push = 1'b1;
            end
            if (status_req) begin
                seq_active_d = 1'b1;
                seq_idx_d    = 2'd0;
                b1_d         = {6'b0, bright_level};
                b2_d         = {6'b0, roll_ctrl};
                ck_d         = SYNC_BYTE ^ {6'b0, bright_level} ^ {6'b0, roll_ctrl};
            end
        end
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            seq_active_q <= 1'b0;
            seq_idx_q    <= '0;
            b1_q         <= '0;
            b2_q         <= '0;
            ck_q         <= '0;
            req_drop_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            seq_active_q <= seq_active_d;
            seq_idx_q    <= seq_idx_d;
            b1_q         <= b1_d;
            b2_q         <= b2_d;
            ck_q         <= ck_d;
            req_drop_q   <= req_drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    // tx is registered: each transition loads the line level for the state being entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
`ifdef UART_STATUS_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shreg_q    <= mem_q[rd_ptr_q[AW-1:0]];
`ifdef UART_STATUS_TX_PARITY_EN
                        parity_q   <= ^mem_q[rd_ptr_q[AW-1:0]];
`endif
                        baud_cnt_q <= '0;
                        tx_q       <= 1'b0;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    if (baud_cnt_q == BAUD_LAST) begin
                        baud_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        tx_q       <= shreg_q[0];
                        state_q    <= S_DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_cnt_q == BAUD_LAST) begin
                        baud_cnt_q <= '0;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_STATUS_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= S_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            shreg_q   <= {1'b0, shreg_q[7:1]};
                            tx_q      <= shreg_q[1];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CW'(1);
                    end
                end
`ifdef UART_STATUS_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_cnt_q == BAUD_LAST) begin
                        baud_cnt_q <= '0;
                        tx_q       <= 1'b1;
                        state_q    <= S_STOP;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CW'(1);
                    end
                end
`endif
                S_STOP: begin
                    tx_q <= 1'b1;
                    if (baud_cnt_q == BAUD_LAST) begin
                        baud_cnt_q <= '0;
                        state_q    <= S_IDLE;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CW'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tx       = tx_q;
    assign tx_ready = !full && !seq_active_q;
    assign busy     = !empty || (state_q != S_IDLE) || seq_active_q;
    assign req_drop = req_drop_q;

endmodule

// File: tb/tb_uart_status_tx.sv
// Bench for uart_status_tx: queue/timer reference model checked every cycle, a line decoder,
// and directed scenarios with hand-computed byte expectations.
module tb_uart_status_tx;

    localparam int unsigned CLK_FREQ = 1_000_000;
    localparam int unsigned BAUD     = 58_823;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned DIV      = CLK_FREQ / BAUD;   // 17
`ifdef UART_STATUS_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int LIMIT = 40 * NBITS * DIV;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       status_req;
    logic [1:0] bright_level;
    logic [1:0] roll_ctrl;
    logic       tx;
    logic       busy;
    logic       req_drop;

    uart_status_tx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .status_req  (status_req),
        .bright_level(bright_level),
        .roll_ctrl   (roll_ctrl),
        .tx          (tx),
        .busy        (busy),
        .req_drop    (req_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic checkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: FIFO as a queue, pending status bytes as a queue, frame as a timer.
    logic [7:0]  mq[$];
    logic [7:0]  sq[$];
    logic [7:0]  sent[$];
    bit          ser_on = 1'b0;
    int unsigned el     = 0;
    logic [7:0]  cur    = '0;
    bit          m_drop = 1'b0;

    function automatic logic m_tx();
        int unsigned idx;
        if (!ser_on) return 1'b1;
        idx = el / DIV;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return cur[idx-1];
        if (idx == 9 && NBITS == 11) return ^cur;
        return 1'b1;
    endfunction

    function automatic logic m_ready();
        return (mq.size() < DEPTH) && (sq.size() == 0);
    endfunction

    function automatic logic m_busy();
        return (mq.size() != 0) || ser_on || (sq.size() != 0);
    endfunction

    always @(posedge clk) begin : model_step
        bit full_b, seq_on_b, rdy_b, pop_b;
        logic [7:0] b1, b2;
        if (!rst_n) begin
            mq.delete();
            sq.delete();
            ser_on = 1'b0;
            el     = 0;
            m_drop = 1'b0;
        end else begin
            full_b   = (mq.size() == DEPTH);
            seq_on_b = (sq.size() != 0);
            rdy_b    = !full_b && !seq_on_b;
            pop_b    = !ser_on && (mq.size() != 0);
            if (ser_on) begin
                el++;
                if (el == NBITS * DIV) ser_on = 1'b0;
            end
            if (pop_b) begin
                cur = mq.pop_front();
                sent.push_back(cur);
                ser_on = 1'b1;
                el     = 0;
            end
            if (seq_on_b) begin
                if (!full_b) mq.push_back(sq.pop_front());
            end else if (tx_valid && rdy_b) begin
                mq.push_back(tx_data);
            end
            m_drop = status_req && seq_on_b;
            if (status_req && !seq_on_b) begin
                b1 = {6'b0, bright_level};
                b2 = {6'b0, roll_ctrl};
                sq.push_back(8'hA5);
                sq.push_back(b1);
                sq.push_back(b2);
                sq.push_back(8'hA5 ^ b1 ^ b2);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check1("tx", tx, m_tx());
            check1("tx_ready", tx_ready, m_ready());
            check1("busy", busy, m_busy());
            check1("req_drop", req_drop, m_drop);
        end
    end

    // Line decoder: samples mid-bit after each falling edge.
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic       rx_prev = 1'b1;
    initial begin : rx_dec
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0 && rx_prev === 1'b1) begin
                repeat (DIV / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = tx;
                end
                repeat ((NBITS - 9) * DIV) @(negedge clk);
                rx_q.push_back(b);
            end
            rx_prev = tx;
        end
    end

    int   falls    = 0;
    int   drop_cnt = 0;
    logic tx_prev  = 1'b1;
    always @(negedge clk) begin
        if (tx_prev === 1'b1 && tx === 1'b0) falls++;
        if (req_drop === 1'b1) drop_cnt++;
        tx_prev = tx;
    end

    task automatic push(input logic [7:0] d);
        int n;
        tx_valid = 1'b1;
        tx_data  = d;
        n = 0;
        while (tx_ready !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        checkn("push_accept_within_bound", (n < LIMIT) ? 1 : 0, 1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkn("idle_within_bound", (n < limit) ? 1 : 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic expect_rx(input string name);
        checkn({name, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            check8($sformatf("%s[%0d]", name, i), rx_q[i], exp_q[i]);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #900_000;
        failures++;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        rst_n        = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = '0;
        status_req   = 1'b0;
        bright_level = '0;
        roll_ctrl    = '0;
        repeat (5) @(negedge clk);
        check1("reset_tx", tx, 1'b1);
        check1("reset_tx_ready", tx_ready, 1'b1);
        check1("reset_busy", busy, 1'b0);
        check1("reset_req_drop", req_drop, 1'b0);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte: tx still high one cycle after acceptance, low the cycle after.
        exp_q.push_back(8'h5A);
        push(8'h5A);
        check1("latency_n1_tx", tx, 1'b1);
        @(negedge clk);
        check1("latency_n2_tx", tx, 1'b0);
        wait_idle(LIMIT);
        expect_rx("single");

        // Status frame: level 2, mode 1 -> A5 02 01 A6.
        bright_level = 2'd2;
        roll_ctrl    = 2'd1;
        status_req   = 1'b1;
        @(negedge clk);
        status_req   = 1'b0;
        bright_level = 2'd0;
        roll_ctrl    = 2'd0;
        check1("status_load_ready", tx_ready, 1'b0);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hA6);
        wait_idle(LIMIT);
        expect_rx("status");

        // FIFO full: one byte on the line, then 9 more back-to-back.
        exp_q.push_back(8'hC3);
        push(8'hC3);
        for (int i = 1; i <= 9; i++) begin
            exp_q.push_back(8'h10 + 8'(i));
            push(8'h10 + 8'(i));
            if (i == 7) check1("fifo_7_ready", tx_ready, 1'b1);
            if (i == 8) check1("fifo_full_ready", tx_ready, 1'b0);
        end
        wait_idle(LIMIT);
        expect_rx("fifo_full");

        // Dropped request two cycles after the first: level 3, mode 2 -> A5 03 02 A4.
        drop_cnt     = 0;
        bright_level = 2'd3;
        roll_ctrl    = 2'd2;
        status_req   = 1'b1;
        @(negedge clk);
        status_req   = 1'b0;
        @(negedge clk);
        status_req   = 1'b1;
        bright_level = 2'd0;
        roll_ctrl    = 2'd0;
        @(negedge clk);
        status_req   = 1'b0;
        check1("req_drop_pulse", req_drop, 1'b1);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'hA4);
        wait_idle(LIMIT);
        checkn("req_drop_count", drop_cnt, 1);
        expect_rx("dropped");

        // Simultaneous byte and request while idle: the byte goes first.
        tx_valid     = 1'b1;
        tx_data      = 8'h3C;
        status_req   = 1'b1;
        bright_level = 2'd1;
        roll_ctrl    = 2'd3;
        check1("simul_ready", tx_ready, 1'b1);
        @(negedge clk);
        tx_valid   = 1'b0;
        status_req = 1'b0;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'hA7);
        wait_idle(LIMIT);
        expect_rx("simul");

        // Reset in the middle of data bit 3 with bytes still queued.
        push(8'h96);
        @(negedge clk);
        check1("midrst_start_tx", tx, 1'b0);
        push(8'h69);
        push(8'hF0);
        repeat (4 * DIV + DIV / 2 - 4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check1("midrst_tx", tx, 1'b1);
        check1("midrst_busy", busy, 1'b0);
        check1("midrst_ready", tx_ready, 1'b1);
        f0 = falls;
        repeat (13 * DIV) @(negedge clk);
        checkn("midrst_no_more_frames", falls - f0, 0);
        rx_q.delete();
        exp_q.delete();

        // Randomized traffic against the model.
        sent.delete();
        for (int c = 0; c < 3000; c++) begin
            tx_valid     = ($urandom_range(0, 99) < 40);
            tx_data      = 8'($urandom);
            status_req   = ($urandom_range(0, 99) < 2);
            bright_level = 2'($urandom);
            roll_ctrl    = 2'($urandom);
            @(negedge clk);
        end
        tx_valid   = 1'b0;
        status_req = 1'b0;
        wait_idle((DEPTH + 8) * (NBITS * DIV + 1));
        checkn("rand_activity", (sent.size() > 10) ? 1 : 0, 1);
        checkn("rand_rx_count", rx_q.size(), sent.size());
        for (int i = 0; i < rx_q.size() && i < sent.size(); i++) begin
            check8($sformatf("rand_rx[%0d]", i), rx_q[i], sent[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
